// File: rtl/acl2_defs_pkg.sv
// Shared opcodes, ADXL362 register addresses and FSM encodings for the ACL2 sample sequencer.
package acl2_defs;

    localparam logic [1:0] OP_REG_READ  = 2'b00;
    localparam logic [1:0] OP_FIFO_READ = 2'b01;
    localparam logic [1:0] OP_WRITE     = 2'b10;

    localparam logic [7:0] XDATA      = 8'h08;
    localparam logic [7:0] YDATA      = 8'h09;
    localparam logic [7:0] ZDATA      = 8'h0A;
    localparam logic [7:0] FILTER_CTL = 8'h2C;
    localparam logic [7:0] POWER_CTL  = 8'h2D;

    localparam logic [2:0] ST_INIT_FILT = 3'd0;
    localparam logic [2:0] ST_INIT_PWR  = 3'd1;
    localparam logic [2:0] ST_WAIT_TICK = 3'd2;
    localparam logic [2:0] ST_RD_X      = 3'd3;
    localparam logic [2:0] ST_RD_Y      = 3'd4;
    localparam logic [2:0] ST_RD_Z      = 3'd5;
    localparam logic [2:0] ST_PUBLISH   = 3'd6;

    localparam logic PH_ISSUE = 1'b0;
    localparam logic PH_WAIT  = 1'b1;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] addr;
        logic [7:0] wdata;
    } spi_cmd_t;

    // Command launched by each transaction state; non-transaction states map to an idle read.
    function automatic spi_cmd_t state_cmd(input logic [2:0] st,
                                           input logic [7:0] filt_cfg,
                                           input logic [7:0] pwr_cfg);
        spi_cmd_t c;
        c.op    = OP_REG_READ;
        c.addr  = 8'h00;
        c.wdata = 8'h00;
        case (st)
            ST_INIT_FILT: begin
                c.op    = OP_WRITE;
                c.addr  = FILTER_CTL;
                c.wdata = filt_cfg;
            end
            ST_INIT_PWR: begin
                c.op    = OP_WRITE;
                c.addr  = POWER_CTL;
                c.wdata = pwr_cfg;
            end
            ST_RD_X: c.addr = XDATA;
            ST_RD_Y: c.addr = YDATA;
            ST_RD_Z: c.addr = ZDATA;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/acl2_tick_gen.sv
// Sample-rate timer: counts 0..PERIOD-1 while enabled and flags the wrap cycle.
module acl2_tick_gen #(
    parameter int PERIOD = 1_000_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    output logic TICK
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!EN) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign TICK = EN && (cnt_q == LAST);

endmodule

// File: rtl/acl2_sample_sequencer.sv
// ADXL362 command sequencer: two configuration writes, then periodic X/Y/Z reads published as
// one triplet per strobe, with a per-transaction watchdog that forces a full reconfigure.
module acl2_sample_sequencer #(
    parameter int         SAMPLE_PERIOD = 1_000_000,
    parameter int         DONE_TIMEOUT  = 65_535,
    parameter logic [7:0] FILTER_CFG    = 8'h13,
    parameter logic [7:0] POWER_CFG     = 8'h02
) (
    input  logic       CLK,
    input  logic       RST,
    output logic       SPI_START,
    output logic [1:0] SPI_OP,
    output logic [7:0] SPI_ADDR,
    output logic [7:0] SPI_WDATA,
    input  logic       SPI_BUSY,
    input  logic       SPI_DONE,
    input  logic [7:0] SPI_RDATA,
    output logic [7:0] ACC_X,
    output logic [7:0] ACC_Y,
    output logic [7:0] ACC_Z,
    output logic       SAMPLE_VALID,
    output logic       CFG_DONE,
    output logic       ERR_TIMEOUT
);

    import acl2_defs::*;

    localparam int WDW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(DONE_TIMEOUT - 1);

    logic [2:0]     state_q, state_d;
    logic           phase_q, phase_d;
    logic [WDW-1:0] wdog_q, wdog_d;
    logic           pend_q, pend_d;
    logic           start_q, start_d;
    logic [1:0]     op_q, op_d;
    logic [7:0]     addr_q, addr_d;
    logic [7:0]     wdata_q, wdata_d;
    logic [7:0]     shx_q, shx_d;
    logic [7:0]     shy_q, shy_d;
    logic [7:0]     shz_q, shz_d;
    logic [7:0]     accx_q, accx_d;
    logic [7:0]     accy_q, accy_d;
    logic [7:0]     accz_q, accz_d;
    logic           valid_q, valid_d;
    logic           cfg_q, cfg_d;
    logic           err_q, err_d;

    logic     tick;
    spi_cmd_t cmd;

    acl2_tick_gen #(
        .PERIOD (SAMPLE_PERIOD)
    ) u_tick (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (cfg_q),
        .TICK (tick)
    );

    assign cmd = state_cmd(state_q, FILTER_CFG, POWER_CFG);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        wdog_d  = wdog_q;
        pend_d  = pend_q;
        start_d = 1'b0;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        shx_d   = shx_q;
        shy_d   = shy_q;
        shz_d   = shz_q;
        accx_d  = accx_q;
        accy_d  = accy_q;
        accz_d  = accz_q;
        valid_d = 1'b0;
        cfg_d   = cfg_q;
        err_d   = err_q;

        case (state_q)
            ST_WAIT_TICK: begin
                if (pend_q) begin
                    pend_d  = 1'b0;
                    state_d = ST_RD_X;
                    phase_d = PH_ISSUE;
                    wdog_d  = '0;
                end
            end

            ST_PUBLISH: begin
                accx_d  = shx_q;
                accy_d  = shy_q;
                accz_d  = shz_q;
                valid_d = 1'b1;
                state_d = ST_WAIT_TICK;
            end

            ST_INIT_FILT, ST_INIT_PWR, ST_RD_X, ST_RD_Y, ST_RD_Z: begin
                if (phase_q == PH_ISSUE) begin
                    wdog_d = '0;
                    if (!SPI_BUSY) begin
                        start_d = 1'b1;
                        op_d    = cmd.op;
                        addr_d  = cmd.addr;
                        wdata_d = cmd.wdata;
                        phase_d = PH_WAIT;
                    end
                end else if (SPI_DONE) begin
                    // DONE is checked ahead of the watchdog so a same-cycle completion wins.
                    phase_d = PH_ISSUE;
                    wdog_d  = '0;
                    case (state_q)
                        ST_INIT_FILT: state_d = ST_INIT_PWR;
                        ST_INIT_PWR: begin
                            cfg_d   = 1'b1;
                            state_d = ST_WAIT_TICK;
                        end
                        ST_RD_X: begin
                            shx_d   = SPI_RDATA;
                            state_d = ST_RD_Y;
                        end
                        ST_RD_Y: begin
                            shy_d   = SPI_RDATA;
                            state_d = ST_RD_Z;
                        end
                        default: begin
                            shz_d   = SPI_RDATA;
                            state_d = ST_PUBLISH;
                        end
                    endcase
                end else if (wdog_q == WD_LAST) begin
                    err_d   = 1'b1;
                    cfg_d   = 1'b0;
                    pend_d  = 1'b0;
                    state_d = ST_INIT_FILT;
                    phase_d = PH_ISSUE;
                    wdog_d  = '0;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_INIT_FILT;
                phase_d = PH_ISSUE;
                wdog_d  = '0;
            end
        endcase

        // A single pending flag: ticks landing while one is outstanding are dropped.
        if (tick && cfg_d) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_INIT_FILT;
            phase_q <= PH_ISSUE;
            wdog_q  <= '0;
            pend_q  <= 1'b0;
            start_q <= 1'b0;
            op_q    <= 2'b00;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            shx_q   <= 8'h00;
            shy_q   <= 8'h00;
            shz_q   <= 8'h00;
            accx_q  <= 8'h00;
            accy_q  <= 8'h00;
            accz_q  <= 8'h00;
            valid_q <= 1'b0;
            cfg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            wdog_q  <= wdog_d;
            pend_q  <= pend_d;
            start_q <= start_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            shx_q   <= shx_d;
            shy_q   <= shy_d;
            shz_q   <= shz_d;
            accx_q  <= accx_d;
            accy_q  <= accy_d;
            accz_q  <= accz_d;
            valid_q <= valid_d;
            cfg_q   <= cfg_d;
            err_q   <= err_d;
        end
    end

    assign SPI_START    = start_q;
    assign SPI_OP       = op_q;
    assign SPI_ADDR     = addr_q;
    assign SPI_WDATA    = wdata_q;
    assign ACC_X        = accx_q;
    assign ACC_Y        = accy_q;
    assign ACC_Z        = accz_q;
    assign SAMPLE_VALID = valid_q;
    assign CFG_DONE     = cfg_q;
    assign ERR_TIMEOUT  = err_q;

endmodule
